// File: rtl/rand_pkg.sv
// Shared constants and types for the random-byte capture path.
package rand_pkg;

    localparam int RAND_BYTE_W    = 8;
    localparam int BITS_PER_BYTE  = 8;
    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DROP_W = 16;

    typedef logic [RAND_BYTE_W-1:0] rand_byte_t;

endpackage

// File: rtl/rand_sync_fifo.sv
// First-word fall-through byte FIFO with level tracking.
// It reports pushes that were refused because the FIFO was full.
module rand_sync_fifo
    import rand_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  rand_byte_t        din,
    input  logic              rdy,
    output rand_byte_t        dout,
    output logic              dout_vld,
    output logic [ADDR_W:0]   level,
    output logic              drop
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    rand_byte_t        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   level_reg, level_next;
    logic              empty, full, pop, push_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LEVEL);
    assign pop     = !empty && rdy;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        if (pop)     rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + (ADDR_W+1)'(1);
            2'b01:   level_next = level_reg - (ADDR_W+1)'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    assign dout     = empty ? '0 : mem[rd_ptr_reg];
    assign dout_vld = !empty;
    assign level    = level_reg;

endmodule

// File: rtl/rand_byte_buffer.sv
// Counts bit strobes into the upstream shifter and queues each completed byte.
// Bytes lost to a full FIFO are flagged and counted.
module rand_byte_buffer
    import rand_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DROP_W = DEFAULT_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              CSReq,
    input  logic [7:0]        randByte,
    input  logic              clr_ovf,
    output logic [7:0]        dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int              CNT_W    = $clog2(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              wr_pend_reg, wr_pend_next;
    logic              overflow_reg, overflow_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic              drop;

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        wr_pend_next = 1'b0;
        if (!en) begin
            bit_cnt_next = '0;
        end else if (CSReq) begin
            if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_next = '0;
                wr_pend_next = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves exactly one recorded loss.
    always_comb begin
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            overflow_next = 1'b1;
            if (clr_ovf)
                drop_cnt_next = DROP_W'(1);
            else if (drop_cnt_reg != '1)
                drop_cnt_next = drop_cnt_reg + DROP_W'(1);
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_reg  <= '0;
            wr_pend_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            bit_cnt_reg  <= bit_cnt_next;
            wr_pend_reg  <= wr_pend_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // The shifter settles one cycle after the 8th strobe, so the pending flag
    // lines the push up with the completed byte.
    rand_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_pend_reg),
        .din      (randByte),
        .rdy      (dout_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .level    (level),
        .drop     (drop)
    );

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_rand_byte_buffer.sv
// Randomised bench for rand_byte_buffer against a queue-based reference model.
module tb_rand_byte_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        CSReq;
    logic [7:0]  randByte;
    logic        clr_ovf;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    rand_byte_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .CSReq    (CSReq),
        .randByte (randByte),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: byte queue, strobe count, pending-push flag, sticky flags.
    logic [7:0] q[$];
    int         m_cnt  = 0;
    bit         m_pend = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_drop = 0;
    logic [7:0] sr     = 8'h00;
    bit         cmp_on = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(bit cs, bit rdy, bit e, bit clr);
        bit pop, push_ok, drop;
        pop     = rdy && (q.size() != 0);
        push_ok = m_pend && ((q.size() < 16) || pop);
        drop    = m_pend && !push_ok;
        if (pop) void'(q.pop_front());
        if (push_ok) q.push_back(sr);
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (!e) begin
            m_cnt  = 0;
            m_pend = 1'b0;
        end else if (cs) begin
            m_pend = (m_cnt == 7);
            m_cnt  = (m_cnt + 1) % 8;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    // One clock cycle: inputs held through the edge, shifter updates after it.
    task automatic cycle(bit cs, bit b, bit rdy, bit e = 1'b1, bit clr = 1'b0);
        CSReq    = cs;
        dout_rdy = rdy;
        en       = e;
        clr_ovf  = clr;
        @(posedge clk);
        if (rst) model_edge(cs, rdy, e, clr);
        #1;
        if (cs) sr = {sr[6:0], b};
        randByte = sr;
    endtask

    task automatic send_bits(int n, bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom), rdy);
    endtask

    task automatic drain();
        repeat (20) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset();
        CSReq = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_dout",  32'(dout),     32'h0);
        chk("rst_vld",   32'(dout_vld), 32'h0);
        chk("rst_level", 32'(level),    32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);
        chk("rst_drop",  32'(drop_cnt), 32'h0);
        q.delete();
        m_cnt  = 0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("dout",     32'(dout),     32'((q.size() != 0) ? q[0] : 8'h00));
            chk("dout_vld", 32'(dout_vld), 32'(q.size() != 0));
            chk("level",    32'(level),    32'(q.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    initial begin
        logic [7:0] pat;
        rst      = 1'b0;
        en       = 1'b1;
        CSReq    = 1'b0;
        clr_ovf  = 1'b0;
        dout_rdy = 1'b0;
        randByte = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("init_vld",   32'(dout_vld), 32'h0);
        chk("init_level", 32'(level),    32'h0);
        chk("init_drop",  32'(drop_cnt), 32'h0);
        cmp_on = 1'b1;

        // Known pattern: one push of 0xB2, visible two cycles after the 8th strobe.
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, pat[7-i], 1'b0);
        end
        chk("t2_vld_early", 32'(dout_vld), 32'h0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t2_dout",  32'(dout),     32'hB2);
        chk("t2_vld",   32'(dout_vld), 32'h1);
        chk("t2_level", 32'(level),    32'h1);
        drain();

        // Continuous strobes with an always-ready consumer.
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, 1'($urandom), 1'b1);
            chk("t3_level_le1", 32'(level <= 5'd1), 32'h1);
        end
        drain();

        // Seventeen bytes into a stalled FIFO.
        send_bits(136, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t4_level", 32'(level),    32'd16);
        chk("t4_ovf",   32'(overflow), 32'h1);
        chk("t4_drop",  32'(drop_cnt), 32'h1);

        // Full FIFO: push and pop together.
        send_bits(8, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t5_level", 32'(level),    32'd16);
        chk("t5_drop",  32'(drop_cnt), 32'h1);
        drain();
        chk("t5_empty", 32'(level), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_ovf",  32'(overflow), 32'h0);
        chk("clr_drop", 32'(drop_cnt), 32'h0);

        // Asynchronous reset with five bytes queued and three strobes counted.
        send_bits(43, 1'b0);
        chk("t1_level_pre", 32'(level), 32'd5);
        async_reset();
        send_bits(7, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_no_push", 32'(level), 32'h0);
        send_bits(1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_push", 32'(level), 32'h1);
        drain();

        // Enable dropped mid-byte, then eight strobes after re-enable.
        send_bits(5, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(7, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t6_no_push", 32'(level), 32'h0);
        send_bits(1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t6_push", 32'(level), 32'h1);

        // Overflow twice, then a clear coinciding with a third drop.
        send_bits(136, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t6_drop2", 32'(drop_cnt), 32'd2);
        send_bits(8, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_clr_ovf",  32'(overflow), 32'h1);
        chk("t6_clr_drop", 32'(drop_cnt), 32'h1);
        drain();

        // Free-running random traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 1'($urandom), ($urandom_range(2, 0) != 0),
                  ($urandom_range(15, 0) != 0), ($urandom_range(31, 0) == 0));
        drain();

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
